operand_issue_scoreboard: RTL and testbench

//  Issue stage between decode and execute; drives the read ports of the register file.

---
 rtl/operand_issue_scoreboard_pkg.sv | 14 +
 rtl/operand_issue_scoreboard_reg_scoreboard.sv | 93 +++++++++
 rtl/operand_issue_scoreboard.sv | 180 ++++++++++++++++++
 tb/tb_operand_issue_scoreboard.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_issue_scoreboard_pkg.sv
// Shared constants for the operand issue stage and its register scoreboard.
// Widths follow the core-wide constants: VADDR_WIDTH is the register address
// width, WORD_WIDTH the operand width. SB_CNT_WIDTH is the per-register
// in-flight write counter width, and SB_MAX_PENDING is its saturation value.
package operand_issue_scoreboard_pkg;

    localparam int VADDR_WIDTH    = 5;
    localparam int WORD_WIDTH     = 32;
    localparam int SB_CNT_WIDTH   = 2;
    localparam int SB_MAX_PENDING = (1 << SB_CNT_WIDTH) - 1;

    localparam logic [WORD_WIDTH-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/operand_issue_scoreboard_reg_scoreboard.sv
// Per-register in-flight write counters.
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   inc_en_i / inc_addr_i    an instruction writing inc_addr_i is issuing
//   dec_en_i / dec_addr_i    writeback to dec_addr_i commits this cycle
//   qN_en_i / qN_addr_i      source query N; qN_hazard_o = must wait
//   full_en_i / full_addr_i  destination query; full_o = counter saturated
//   err_o                    sticky: writeback found no pending write
// Register 0 is never counted and never reports a hazard.
module operand_issue_scoreboard_reg_scoreboard
    import operand_issue_scoreboard_pkg::*;
#(
    parameter int ADDR_W = VADDR_WIDTH,
    parameter int CNT_W  = SB_CNT_WIDTH
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              inc_en_i,
    input  logic [ADDR_W-1:0] inc_addr_i,
    input  logic              dec_en_i,
    input  logic [ADDR_W-1:0] dec_addr_i,
    input  logic              q1_en_i,
    input  logic [ADDR_W-1:0] q1_addr_i,
    output logic              q1_hazard_o,
    input  logic              q2_en_i,
    input  logic [ADDR_W-1:0] q2_addr_i,
    output logic              q2_hazard_o,
    input  logic              full_en_i,
    input  logic [ADDR_W-1:0] full_addr_i,
    output logic              full_o,
    output logic              err_o
);

    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q [NUM_REGS];
    logic [CNT_W-1:0] cnt_d [NUM_REGS];
    logic             err_q, err_d;
    logic             inc_live, dec_live, same_reg;

    // An increment and a decrement on the same register cancel out, and that
    // also suppresses the underflow error for that register.
    always_comb begin
        cnt_d    = cnt_q;
        err_d    = err_q;
        inc_live = inc_en_i && (inc_addr_i != '0);
        dec_live = dec_en_i && (dec_addr_i != '0);
        same_reg = inc_live && dec_live && (inc_addr_i == dec_addr_i);
        if (inc_live && !same_reg) begin
            cnt_d[inc_addr_i] = cnt_q[inc_addr_i] + CNT_ONE;
        end
        if (dec_live && !same_reg) begin
            if (cnt_q[dec_addr_i] == '0) begin
                err_d = 1'b1;
            end else begin
                cnt_d[dec_addr_i] = cnt_q[dec_addr_i] - CNT_ONE;
            end
        end
    end

    // A single pending write is resolved by a writeback in the same cycle
    // (the top bypasses its data); two or more are not.
    always_comb begin
        q1_hazard_o = q1_en_i && (q1_addr_i != '0) &&
                      ((cnt_q[q1_addr_i] > CNT_ONE) ||
                       ((cnt_q[q1_addr_i] == CNT_ONE) &&
                        !(dec_en_i && (dec_addr_i == q1_addr_i))));
        q2_hazard_o = q2_en_i && (q2_addr_i != '0) &&
                      ((cnt_q[q2_addr_i] > CNT_ONE) ||
                       ((cnt_q[q2_addr_i] == CNT_ONE) &&
                        !(dec_en_i && (dec_addr_i == q2_addr_i))));
        full_o      = full_en_i && (full_addr_i != '0) &&
                      (cnt_q[full_addr_i] == CNT_MAX) &&
                      !(dec_en_i && (dec_addr_i == full_addr_i));
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: rtl/operand_issue_scoreboard.sv
// Issue stage between decode and execute.
// Holds one decoded instruction (S1), drives the register file read addresses
// from it, checks the scoreboard for RAW hazards and counter saturation, and
// captures operands (with writeback bypass) into the execute-facing register.
// Ports:
//   clk_i, rst_ni                 clock, synchronous active-low reset
//   dec_*                         decode handshake and instruction fields
//   rf_addr_src*_o / rf_data_*_i  register file read ports
//   wb_valid_i, wb_rd_i, wb_data_i writeback commit (RF updated next posedge)
//   ex_*                          execute handshake, operands, destination
//   sb_err_o                      sticky writeback-without-pending error
module operand_issue_scoreboard
    import operand_issue_scoreboard_pkg::*;
#(
    parameter int ADDR_W = VADDR_WIDTH,
    parameter int DATA_W = WORD_WIDTH,
    parameter int CNT_W  = SB_CNT_WIDTH
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              dec_valid_i,
    output logic              dec_ready_o,
    input  logic [ADDR_W-1:0] dec_rs1_i,
    input  logic [ADDR_W-1:0] dec_rs2_i,
    input  logic              dec_use_rs1_i,
    input  logic              dec_use_rs2_i,
    input  logic [ADDR_W-1:0] dec_rd_i,
    input  logic              dec_we_i,
    output logic [ADDR_W-1:0] rf_addr_src1_o,
    output logic [ADDR_W-1:0] rf_addr_src2_o,
    input  logic [DATA_W-1:0] rf_data_src1_i,
    input  logic [DATA_W-1:0] rf_data_src2_i,
    input  logic              wb_valid_i,
    input  logic [ADDR_W-1:0] wb_rd_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic              ex_valid_o,
    input  logic              ex_ready_i,
    output logic [DATA_W-1:0] ex_op1_o,
    output logic [DATA_W-1:0] ex_op2_o,
    output logic [ADDR_W-1:0] ex_rd_o,
    output logic              ex_we_o,
    output logic              sb_err_o
);

    logic              s1_valid_q, s1_valid_d;
    logic [ADDR_W-1:0] s1_rs1_q, s1_rs1_d, s1_rs2_q, s1_rs2_d, s1_rd_q, s1_rd_d;
    logic              s1_use_rs1_q, s1_use_rs1_d, s1_use_rs2_q, s1_use_rs2_d;
    logic              s1_we_q, s1_we_d;

    logic              ex_valid_q, ex_valid_d;
    logic [DATA_W-1:0] ex_op1_q, ex_op1_d, ex_op2_q, ex_op2_d;
    logic [ADDR_W-1:0] ex_rd_q, ex_rd_d;
    logic              ex_we_q, ex_we_d;

    logic              hazard1, hazard2, full;
    logic              issue, dec_ready;
    logic [DATA_W-1:0] op1, op2;

    operand_issue_scoreboard_reg_scoreboard #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_reg_scoreboard (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .inc_en_i    (issue && s1_we_q),
        .inc_addr_i  (s1_rd_q),
        .dec_en_i    (wb_valid_i),
        .dec_addr_i  (wb_rd_i),
        .q1_en_i     (s1_use_rs1_q),
        .q1_addr_i   (s1_rs1_q),
        .q1_hazard_o (hazard1),
        .q2_en_i     (s1_use_rs2_q),
        .q2_addr_i   (s1_rs2_q),
        .q2_hazard_o (hazard2),
        .full_en_i   (s1_we_q),
        .full_addr_i (s1_rd_q),
        .full_o      (full),
        .err_o       (sb_err_o)
    );

    // The register file has not yet absorbed this cycle's writeback, so a
    // matching writeback must win over the read data.
    always_comb begin
        op1 = ZERO_WORD[DATA_W-1:0];
        op2 = ZERO_WORD[DATA_W-1:0];
        if (s1_use_rs1_q && (s1_rs1_q != '0)) begin
            op1 = (wb_valid_i && (wb_rd_i == s1_rs1_q)) ? wb_data_i : rf_data_src1_i;
        end
        if (s1_use_rs2_q && (s1_rs2_q != '0)) begin
            op2 = (wb_valid_i && (wb_rd_i == s1_rs2_q)) ? wb_data_i : rf_data_src2_i;
        end
    end

    // Issue and accept in the same cycle lets S1 refill without a bubble.
    always_comb begin
        issue     = s1_valid_q && !hazard1 && !hazard2 && !full &&
                    (!ex_valid_q || ex_ready_i);
        dec_ready = !s1_valid_q || issue;
    end

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_rs1_d     = s1_rs1_q;
        s1_rs2_d     = s1_rs2_q;
        s1_use_rs1_d = s1_use_rs1_q;
        s1_use_rs2_d = s1_use_rs2_q;
        s1_rd_d      = s1_rd_q;
        s1_we_d      = s1_we_q;
        if (dec_valid_i && dec_ready) begin
            s1_valid_d   = 1'b1;
            s1_rs1_d     = dec_rs1_i;
            s1_rs2_d     = dec_rs2_i;
            s1_use_rs1_d = dec_use_rs1_i;
            s1_use_rs2_d = dec_use_rs2_i;
            s1_rd_d      = dec_rd_i;
            s1_we_d      = dec_we_i;
        end else if (issue) begin
            s1_valid_d = 1'b0;
        end
    end

    // The EX register only changes on issue, so it stays stable while
    // execute is applying backpressure.
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_op1_d   = ex_op1_q;
        ex_op2_d   = ex_op2_q;
        ex_rd_d    = ex_rd_q;
        ex_we_d    = ex_we_q;
        if (issue) begin
            ex_valid_d = 1'b1;
            ex_op1_d   = op1;
            ex_op2_d   = op2;
            ex_rd_d    = s1_rd_q;
            ex_we_d    = s1_we_q;
        end else if (ex_ready_i) begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_valid_q   <= 1'b0;
            s1_rs1_q     <= '0;
            s1_rs2_q     <= '0;
            s1_use_rs1_q <= 1'b0;
            s1_use_rs2_q <= 1'b0;
            s1_rd_q      <= '0;
            s1_we_q      <= 1'b0;
            ex_valid_q   <= 1'b0;
            ex_op1_q     <= '0;
            ex_op2_q     <= '0;
            ex_rd_q      <= '0;
            ex_we_q      <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_rs1_q     <= s1_rs1_d;
            s1_rs2_q     <= s1_rs2_d;
            s1_use_rs1_q <= s1_use_rs1_d;
            s1_use_rs2_q <= s1_use_rs2_d;
            s1_rd_q      <= s1_rd_d;
            s1_we_q      <= s1_we_d;
            ex_valid_q   <= ex_valid_d;
            ex_op1_q     <= ex_op1_d;
            ex_op2_q     <= ex_op2_d;
            ex_rd_q      <= ex_rd_d;
            ex_we_q      <= ex_we_d;
        end
    end

    assign dec_ready_o    = dec_ready;
    assign rf_addr_src1_o = s1_rs1_q;
    assign rf_addr_src2_o = s1_rs2_q;
    assign ex_valid_o     = ex_valid_q;
    assign ex_op1_o       = ex_op1_q;
    assign ex_op2_o       = ex_op2_q;
    assign ex_rd_o        = ex_rd_q;
    assign ex_we_o        = ex_we_q;

endmodule

// File: tb/tb_operand_issue_scoreboard.sv
// Testbench for operand_issue_scoreboard: directed scenarios with literal
// expectations, then randomized traffic, all checked every cycle against a
// transaction-level model that tracks in-flight writes as a plain list.
module tb_operand_issue_scoreboard;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          dec_valid_i, dec_ready_o;
    logic [AW-1:0] dec_rs1_i, dec_rs2_i, dec_rd_i;
    logic          dec_use_rs1_i, dec_use_rs2_i, dec_we_i;
    logic [AW-1:0] rf_addr_src1_o, rf_addr_src2_o;
    logic [DW-1:0] rf_data_src1_i, rf_data_src2_i;
    logic          wb_valid_i;
    logic [AW-1:0] wb_rd_i;
    logic [DW-1:0] wb_data_i;
    logic          ex_valid_o, ex_ready_i;
    logic [DW-1:0] ex_op1_o, ex_op2_o;
    logic [AW-1:0] ex_rd_o;
    logic          ex_we_o, sb_err_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    operand_issue_scoreboard dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .dec_valid_i    (dec_valid_i),
        .dec_ready_o    (dec_ready_o),
        .dec_rs1_i      (dec_rs1_i),
        .dec_rs2_i      (dec_rs2_i),
        .dec_use_rs1_i  (dec_use_rs1_i),
        .dec_use_rs2_i  (dec_use_rs2_i),
        .dec_rd_i       (dec_rd_i),
        .dec_we_i       (dec_we_i),
        .rf_addr_src1_o (rf_addr_src1_o),
        .rf_addr_src2_o (rf_addr_src2_o),
        .rf_data_src1_i (rf_data_src1_i),
        .rf_data_src2_i (rf_data_src2_i),
        .wb_valid_i     (wb_valid_i),
        .wb_rd_i        (wb_rd_i),
        .wb_data_i      (wb_data_i),
        .ex_valid_o     (ex_valid_o),
        .ex_ready_i     (ex_ready_i),
        .ex_op1_o       (ex_op1_o),
        .ex_op2_o       (ex_op2_o),
        .ex_rd_o        (ex_rd_o),
        .ex_we_o        (ex_we_o),
        .sb_err_o       (sb_err_o)
    );

    // Register file: preset contents on reset, written at posedge by
    // writeback, read data latched on negedge from the DUT's addresses.
    logic [DW-1:0] rf_mem [32];

    function automatic logic [DW-1:0] rfPreset(input int i);
        case (i)
            0:       return 32'h0;
            1:       return 32'h5;
            2:       return 32'h7;
            5:       return 32'h55;
            6:       return 32'h66;
            default: return 32'h1000_0000 + 32'(i) * 32'h0101;
        endcase
    endfunction

    always @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= rfPreset(i);
        end else if (wb_valid_i && (wb_rd_i != 5'd0)) begin
            rf_mem[wb_rd_i] <= wb_data_i;
        end
    end

    always @(negedge clk_i) begin
        rf_data_src1_i <= rf_mem[rf_addr_src1_o];
        rf_data_src2_i <= rf_mem[rf_addr_src2_o];
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: S1 slot, EX register, sticky error, and the list of
    // issued-but-not-written-back destinations.
    // ------------------------------------------------------------------
    logic          m_init = 1'b0;
    logic          m_s1v, m_u1, m_u2, m_we;
    logic [AW-1:0] m_rs1, m_rs2, m_rd;
    logic          m_exv, m_exwe, m_err, m_accepted;
    logic [DW-1:0] m_op1, m_op2;
    logic [AW-1:0] m_exrd;
    logic [AW-1:0] inflight [$];

    function automatic int pending(input logic [AW-1:0] r);
        int n = 0;
        foreach (inflight[i]) if (inflight[i] == r) n++;
        return n;
    endfunction

    function automatic logic wbHit(input logic [AW-1:0] r);
        return wb_valid_i && (wb_rd_i == r);
    endfunction

    function automatic logic srcBlocked(input logic use_src, input logic [AW-1:0] rs);
        if (!use_src || rs == 5'd0) return 1'b0;
        return (pending(rs) > 1) || (pending(rs) == 1 && !wbHit(rs));
    endfunction

    function automatic logic [DW-1:0] operand(input logic use_src, input logic [AW-1:0] rs);
        if (!use_src || rs == 5'd0) return '0;
        if (wbHit(rs)) return wb_data_i;
        return rf_mem[rs];
    endfunction

    task automatic modelStep();
        logic exp_issue, exp_ready;
        int   idx;
        exp_issue = 1'b0;
        exp_ready = 1'b0;
        if (m_init) begin
            exp_issue = m_s1v && !srcBlocked(m_u1, m_rs1) && !srcBlocked(m_u2, m_rs2) &&
                        !(m_we && m_rd != 5'd0 && pending(m_rd) >= 3 && !wbHit(m_rd)) &&
                        (!m_exv || ex_ready_i);
            exp_ready = !m_s1v || exp_issue;
            checkOutput("dec_ready", 32'(dec_ready_o), 32'(exp_ready));
            checkOutput("ex_valid", 32'(ex_valid_o), 32'(m_exv));
            checkOutput("ex_op1", ex_op1_o, m_op1);
            checkOutput("ex_op2", ex_op2_o, m_op2);
            checkOutput("ex_rd", 32'(ex_rd_o), 32'(m_exrd));
            checkOutput("ex_we", 32'(ex_we_o), 32'(m_exwe));
            checkOutput("sb_err", 32'(sb_err_o), 32'(m_err));
            if (m_s1v) begin
                checkOutput("rf_addr1", 32'(rf_addr_src1_o), 32'(m_rs1));
                checkOutput("rf_addr2", 32'(rf_addr_src2_o), 32'(m_rs2));
            end
        end
        if (!rst_ni) begin
            m_init = 1'b1;
            m_s1v = 1'b0; m_u1 = 1'b0; m_u2 = 1'b0; m_we = 1'b0;
            m_rs1 = '0; m_rs2 = '0; m_rd = '0;
            m_exv = 1'b0; m_op1 = '0; m_op2 = '0; m_exrd = '0; m_exwe = 1'b0;
            m_err = 1'b0; m_accepted = 1'b0;
            inflight.delete();
        end else if (m_init) begin
            m_accepted = dec_valid_i && exp_ready;
            if (exp_issue) begin
                m_exv  = 1'b1;
                m_op1  = operand(m_u1, m_rs1);
                m_op2  = operand(m_u2, m_rs2);
                m_exrd = m_rd;
                m_exwe = m_we;
                if (m_we && m_rd != 5'd0) inflight.push_back(m_rd);
            end else if (ex_ready_i) begin
                m_exv = 1'b0;
            end
            if (wb_valid_i && wb_rd_i != 5'd0) begin
                idx = -1;
                foreach (inflight[i]) if (idx < 0 && inflight[i] == wb_rd_i) idx = i;
                if (idx < 0) m_err = 1'b1;
                else inflight.delete(idx);
            end
            if (m_accepted) begin
                m_s1v = 1'b1;
                m_rs1 = dec_rs1_i; m_rs2 = dec_rs2_i;
                m_u1 = dec_use_rs1_i; m_u2 = dec_use_rs2_i;
                m_rd = dec_rd_i; m_we = dec_we_i;
            end else if (exp_issue) begin
                m_s1v = 1'b0;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk_i);
            modelStep();
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic applyStimulus(input logic dv, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                                 input logic u1, input logic u2, input logic [AW-1:0] rd,
                                 input logic we, input logic wbv, input logic [AW-1:0] wbrd,
                                 input logic [DW-1:0] wbd, input logic exr);
        dec_valid_i = dv;   dec_rs1_i = rs1;     dec_rs2_i = rs2;
        dec_use_rs1_i = u1; dec_use_rs2_i = u2;  dec_rd_i = rd;  dec_we_i = we;
        wb_valid_i = wbv;   wb_rd_i = wbrd;      wb_data_i = wbd;
        ex_ready_i = exr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input logic exr);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, exr);
    endtask

    task automatic writeBack(input logic [AW-1:0] rd, input logic [DW-1:0] d);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, rd, d, 1);
    endtask

    logic          r_dv, r_u1, r_u2, r_we, r_wbv, r_exr;
    logic [AW-1:0] r_rs1, r_rs2, r_rd, r_wbrd;

    initial begin
        rst_ni = 1'b0;
        idle(1);
        tick();
        tick();
        checkOutput("reset ex_valid", 32'(ex_valid_o), 32'h0);
        checkOutput("reset sb_err", 32'(sb_err_o), 32'h0);
        checkOutput("reset ex_op1", ex_op1_o, 32'h0);
        rst_ni = 1'b1;

        $display("[TB] back-to-back independent ops");
        applyStimulus(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 1);
        checkOutput("b2b ready0", 32'(dec_ready_o), 32'h1);
        tick();
        applyStimulus(1, 5, 6, 1, 1, 4, 1, 0, 0, 0, 1);
        checkOutput("b2b ready1", 32'(dec_ready_o), 32'h1);
        tick();
        checkOutput("b2b op1 A", ex_op1_o, 32'h5);
        checkOutput("b2b op2 A", ex_op2_o, 32'h7);
        checkOutput("b2b rd A", 32'(ex_rd_o), 32'd3);

        $display("[TB] RAW stall then bypass");
        applyStimulus(1, 3, 0, 1, 0, 8, 1, 0, 0, 0, 1);
        tick();
        checkOutput("b2b op1 B", ex_op1_o, 32'h55);
        checkOutput("b2b op2 B", ex_op2_o, 32'h66);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("raw stall ready", 32'(dec_ready_o), 32'h0);
        tick();
        checkOutput("raw stall ex_valid", 32'(ex_valid_o), 32'h0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("raw stall ready2", 32'(dec_ready_o), 32'h0);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 3, 32'h2A, 1);
        checkOutput("bypass ready", 32'(dec_ready_o), 32'h1);
        tick();
        checkOutput("bypass op1", ex_op1_o, 32'h2A);
        checkOutput("bypass rd", 32'(ex_rd_o), 32'd8);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 4, 32'h44, 1);
        checkOutput("r0 ready", 32'(dec_ready_o), 32'h1);
        tick();
        checkOutput("r0 op1", ex_op1_o, 32'h0);
        checkOutput("r0 we", 32'(ex_we_o), 32'h0);
        writeBack(8, 32'h88);
        tick();

        $display("[TB] stall with two pending writes");
        applyStimulus(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 1);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 1);
        tick();
        applyStimulus(1, 3, 0, 1, 0, 10, 1, 0, 0, 0, 1);
        tick();
        writeBack(3, 32'h1);
        checkOutput("cnt2 stall ready", 32'(dec_ready_o), 32'h0);
        tick();
        checkOutput("cnt2 stall ex_valid", 32'(ex_valid_o), 32'h0);
        writeBack(3, 32'h77);
        checkOutput("cnt1 wb ready", 32'(dec_ready_o), 32'h1);
        tick();
        checkOutput("cnt1 wb op1", ex_op1_o, 32'h77);

        $display("[TB] backpressure");
        applyStimulus(1, 1, 2, 1, 1, 11, 1, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 2; i++) begin
            idle(0);
            checkOutput("bp ready", 32'(dec_ready_o), 32'h0);
            tick();
            checkOutput("bp hold op1", ex_op1_o, 32'h77);
        end
        idle(1);
        checkOutput("bp release ready", 32'(dec_ready_o), 32'h1);
        tick();
        checkOutput("bp release op2", ex_op2_o, 32'h7);
        checkOutput("bp release rd", 32'(ex_rd_o), 32'd11);
        writeBack(10, 32'hA0);
        tick();
        writeBack(11, 32'hB0);
        tick();

        $display("[TB] counter saturation on r7");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 1);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            idle(1);
            checkOutput("overflow ready", 32'(dec_ready_o), 32'h0);
            tick();
        end
        writeBack(7, 32'h70);
        checkOutput("overflow release", 32'(dec_ready_o), 32'h1);
        tick();
        for (int i = 0; i < 3; i++) begin
            writeBack(7, 32'h71 + 32'(i));
            tick();
        end

        $display("[TB] writeback without pending write");
        writeBack(9, 32'h99);
        tick();
        checkOutput("sb_err set", 32'(sb_err_o), 32'h1);
        idle(1);
        tick();
        checkOutput("sb_err sticky", 32'(sb_err_o), 32'h1);

        $display("[TB] reset during stall");
        applyStimulus(1, 0, 0, 0, 0, 12, 1, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 12, 0, 1, 0, 13, 1, 0, 0, 0, 0);
        tick();
        checkOutput("pre-reset ex_valid", 32'(ex_valid_o), 32'h1);
        rst_ni = 1'b0;
        applyStimulus(1, 12, 0, 1, 0, 13, 1, 0, 0, 0, 0);
        tick();
        checkOutput("mid reset ex_valid", 32'(ex_valid_o), 32'h0);
        checkOutput("mid reset sb_err", 32'(sb_err_o), 32'h0);
        checkOutput("mid reset ex_rd", 32'(ex_rd_o), 32'h0);
        rst_ni = 1'b1;
        applyStimulus(1, 12, 0, 1, 0, 13, 1, 0, 0, 0, 1);
        checkOutput("post reset ready", 32'(dec_ready_o), 32'h1);
        tick();
        idle(1);
        checkOutput("counters cleared", 32'(dec_ready_o), 32'h1);
        tick();
        writeBack(13, 32'hD0);
        tick();

        $display("[TB] randomized traffic");
        r_dv = 1'b0;
        r_rs1 = '0; r_rs2 = '0; r_rd = '0; r_u1 = 1'b0; r_u2 = 1'b0; r_we = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!r_dv || m_accepted) begin
                r_dv  = ($urandom_range(0, 3) != 0);
                r_rs1 = 5'($urandom_range(0, 7));
                r_rs2 = 5'($urandom_range(0, 7));
                r_rd  = 5'($urandom_range(0, 7));
                r_u1  = ($urandom_range(0, 3) != 0);
                r_u2  = ($urandom_range(0, 3) != 0);
                r_we  = ($urandom_range(0, 3) != 0);
            end
            r_wbv  = 1'b0;
            r_wbrd = '0;
            if (inflight.size() > 0 && $urandom_range(0, 1) == 1) begin
                r_wbv  = 1'b1;
                r_wbrd = inflight[$urandom_range(0, inflight.size() - 1)];
            end
            r_exr = ($urandom_range(0, 3) != 0);
            applyStimulus(r_dv, r_rs1, r_rs2, r_u1, r_u2, r_rd, r_we,
                          r_wbv, r_wbrd, $urandom, r_exr);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
